// File: rtl/key_led_pkg.sv
// key_led_pkg: shared widths, LED bit positions, and the key-to-LED decode
// function used by key_led_top.
//   KEY_W / LED_W    : datapath widths (2 bits each)
//   LED_AND_IDX      : led bit that shows the AND of both keys
//   LED_OR_IDX       : led bit that shows the OR of both keys
//   led_logic(key)   : returns the active-high LED code for a filtered key pair
package key_led_pkg;
  localparam int KEY_W       = 2;
  localparam int LED_W       = 2;
  localparam int LED_AND_IDX = 0;
  localparam int LED_OR_IDX  = 1;

  function automatic logic [LED_W-1:0] led_logic(input logic [KEY_W-1:0] key);
    logic [LED_W-1:0] code;
    code              = '0;
    code[LED_AND_IDX] = &key;
    code[LED_OR_IDX]  = |key;
    return code;
  endfunction
endpackage

// File: rtl/key_sync_debounce.sv
// key_sync_debounce: brings the raw key levels into the clk domain through a
// SYNC_STAGES-deep flop chain per bit and, when KEY_DEBOUNCE_EN is defined,
// filters each synced bit with a per-bit debouncer.
// Configuration macro: KEY_DEBOUNCE_EN (undefined: filtered keys = synced keys).
// Ports:
//   clk       in   system clock
//   rst_n     in   asynchronous active-low reset
//   key_raw   in   raw asynchronous key levels, KEY_W bits
//   key_filt  out  synchronized (and optionally debounced) keys, KEY_W bits
module key_sync_debounce
  import key_led_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [KEY_W-1:0] key_raw,
  output logic [KEY_W-1:0] key_filt
);

  if (SYNC_STAGES < 2)     begin : g_bad_sync $error("SYNC_STAGES must be >= 2");     end
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_db   $error("DEBOUNCE_CYCLES must be >= 1"); end

  // sync_q[0] is the first (metastability-catching) stage
  logic [SYNC_STAGES-1:0][KEY_W-1:0] sync_q;
  logic [KEY_W-1:0]                  synced;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], key_raw};
  end

  assign synced = sync_q[SYNC_STAGES-1];

`ifdef KEY_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  for (genvar b = 0; b < KEY_W; b++) begin : g_db
    logic             acc;
    logic [CNT_W-1:0] cnt;

    // cnt counts consecutive cycles where synced differs from acc. With two
    // levels, "differs" can only mean one value, so a bounce back to acc is
    // what restarts the count. Acceptance happens on the DEBOUNCE_CYCLES-th
    // differing cycle, so cnt never passes CNT_LAST and cannot wrap.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        acc <= 1'b0;
        cnt <= '0;
      end else if (synced[b] == acc) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        acc <= synced[b];
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end

    assign key_filt[b] = acc;
  end
`else
  assign key_filt = synced;
`endif

endmodule

// File: rtl/key_led_top.sv
// key_led_top: board-level key-to-LED block. Two raw keys are synchronized
// (and optionally debounced), decoded to led[0]=AND, led[1]=OR, registered,
// and optionally inverted after the register for active-low LEDs.
// Configuration macro: KEY_DEBOUNCE_EN (enables the per-bit debouncer).
// Ports:
//   clk     in   system clock, all state on rising edge
//   rst_n   in   asynchronous active-low reset
//   key_sw  in   raw key/switch levels, 1 = pressed
//   led     out  registered LED drive
module key_led_top
  import key_led_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int LED_ACTIVE_LOW  = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [KEY_W-1:0] key_sw,
  output logic [LED_W-1:0] led
);

  localparam logic [LED_W-1:0] POL = (LED_ACTIVE_LOW != 0) ? '1 : '0;

  logic [KEY_W-1:0] key_filt;
  logic [LED_W-1:0] led_q;

  key_sync_debounce #(
    .SYNC_STAGES     (SYNC_STAGES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_key (
    .clk      (clk),
    .rst_n    (rst_n),
    .key_raw  (key_sw),
    .key_filt (key_filt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) led_q <= '0;
    else        led_q <= led_logic(key_filt);
  end

  // Inversion sits after the register so reset shows all LEDs off on
  // active-low boards as well.
  assign led = led_q ^ POL;

endmodule

// File: tb/tb_key_led_top.sv
module tb_key_led_top;
  localparam int SS  = 2;
  localparam int DC  = 4;
  localparam int LAL = 0;
  localparam logic [1:0] MASK = (LAL != 0) ? 2'b11 : 2'b00;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] key_sw = 2'b00;
  logic [1:0] led;

  int checks = 0;
  int errors = 0;

  key_led_top #(.SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DC), .LED_ACTIVE_LOW(LAL)) dut (
    .clk(clk), .rst_n(rst_n), .key_sw(key_sw), .led(led)
  );

  always #5 clk = ~clk;

  // Reference: led after edge N is the AND/OR code of the keys as they stood
  // SYNC_STAGES samples earlier; with debouncing, of the accepted key, which
  // flips only once the synced stream has shown the other value for DC
  // samples in a row.
  function automatic logic [1:0] ref_led(input logic [1:0] k);
    return {k[0] | k[1], k[0] & k[1]} ^ MASK;
  endfunction

  logic [1:0] expq[$];
  logic [1:0] hist[64];   // hist[0] = key sampled at the latest edge
  logic [1:0] acc;
  logic [1:0] prev_acc;
  logic       all_diff;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      expq.delete();
      for (int i = 0; i < 64; i++) hist[i] = 2'b00;
      acc = 2'b00;
    end else begin
      for (int i = 63; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = key_sw;
`ifdef KEY_DEBOUNCE_EN
      prev_acc = acc;
      for (int b = 0; b < 2; b++) begin
        all_diff = 1'b1;
        for (int j = 0; j < DC; j++)
          if (hist[SS+j][b] == prev_acc[b]) all_diff = 1'b0;
        if (all_diff) acc[b] = ~prev_acc[b];
      end
      expq.push_back(ref_led(prev_acc));
`else
      expq.push_back(ref_led(hist[SS]));
`endif
    end
  end

  // Monitor: compare on the falling edge, away from the update edge.
  logic [1:0] exp_led;
  always @(negedge clk) begin
    if (!rst_n) begin
      checks++;
      if (led !== MASK) begin
        errors++;
        $display("FAIL reset_led got=%b want=%b t=%0t", led, MASK, $time);
      end
    end else if (expq.size() > 0) begin
      exp_led = expq.pop_front();
      checks++;
      if (led !== exp_led) begin
        errors++;
        $display("FAIL led_stream got=%b want=%b key=%b t=%0t", led, exp_led, key_sw, $time);
      end
    end
  end

  task automatic hold(input logic [1:0] k, input int n);
    key_sw = k;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    // reset with both keys pressed, then release
    rst_n  = 1'b0;
    key_sw = 2'b11;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    hold(2'b11, 10);

    // truth table, each held 10 cycles
    hold(2'b00, 10);
    hold(2'b01, 10);
    hold(2'b10, 10);
    hold(2'b11, 10);

    // both bits flipping together
    hold(2'b01, 10);
    hold(2'b10, 10);
    hold(2'b01, 10);

`ifdef KEY_DEBOUNCE_EN
    hold(2'b00, 12);
    hold(2'b01, 2);
    hold(2'b00, 12);
    hold(2'b01, 6);
    hold(2'b00, 12);
`endif

    repeat (150) hold(2'($urandom_range(0, 3)), $urandom_range(1, 8));

    // asynchronous reset between edges
    hold(2'b11, 12);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (led !== MASK) begin
      errors++;
      $display("FAIL async_reset got=%b want=%b t=%0t", led, MASK, $time);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    hold(2'b11, 10);

    repeat (100) hold(2'($urandom_range(0, 3)), $urandom_range(1, 8));
    hold(2'b00, 12);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
